// File: rtl/input_spike_encoder.sv
// Sparse spike encoder for conv_1_1: holds one binary frame and streams its active
// (channel,row,col) events in raster order. Optional event counter: INPUT_SPIKE_EVENT_COUNT_EN.
module input_spike_encoder #(
    parameter  int FRAME_WIDTH    = 32,
    parameter  int INPUT_CHANNELS = 3,
    localparam int FRAME_SIZE     = FRAME_WIDTH * FRAME_WIDTH,
    localparam int ADDR_W         = $clog2(FRAME_SIZE),
    localparam int COORD_W        = $clog2(FRAME_WIDTH),
    localparam int CH_W           = (INPUT_CHANNELS > 2) ? $clog2(INPUT_CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      bm_wr_en,
    input  logic [ADDR_W-1:0]         bm_wr_addr,
    input  logic [INPUT_CHANNELS-1:0] bm_wr_data,
    input  logic                      input_avail,
    output logic                      ev_valid,
    input  logic                      ev_ready,
    output logic [CH_W-1:0]           ev_ch,
    output logic [COORD_W-1:0]        ev_row,
    output logic [COORD_W-1:0]        ev_col,
    output logic                      ts_done,
    output logic                      busy,
    output logic [2:0]                state_dbg
`ifdef INPUT_SPIKE_EVENT_COUNT_EN
    ,
    output logic [ADDR_W+CH_W:0]      ev_count
`endif
);

    // Handshake: an event transfers on any rising clk edge where ev_valid && ev_ready;
    // while ev_valid is high and ev_ready low, ev_ch/ev_row/ev_col hold and ev_valid stays high.

    typedef enum logic [2:0] {S_IDLE, S_READ, S_LOAD, S_EMIT, S_DONE} state_t;

    state_t                    state;
    logic [INPUT_CHANNELS-1:0] mem [FRAME_SIZE];
    logic [INPUT_CHANNELS-1:0] rd_data;
    logic [INPUT_CHANNELS-1:0] pending;
    logic [INPUT_CHANNELS-1:0] remaining;
    logic [ADDR_W-1:0]         pix;
    logic [COORD_W-1:0]        row;
    logic [COORD_W-1:0]        col;
    logic                      avail_q;
    logic                      last_pix;
    logic                      col_wrap;
    logic                      advance;

    assign state_dbg = state;
    assign last_pix  = (pix == ADDR_W'(FRAME_SIZE - 1));
    assign col_wrap  = (col == COORD_W'(FRAME_WIDTH - 1));
    assign remaining = pending & ~(INPUT_CHANNELS'(1) << ev_ch);
    assign advance   = ((state == S_LOAD) && (rd_data == '0)) ||
                       ((state == S_EMIT) && ev_ready && (remaining == '0));

    function automatic logic [CH_W-1:0] lowest_ch(input logic [INPUT_CHANNELS-1:0] m);
        lowest_ch = '0;
        for (int c = INPUT_CHANNELS - 1; c >= 0; c--) begin
            if (m[c]) lowest_ch = CH_W'(c);
        end
    endfunction

    // Bitmap storage: read-before-write, so a same-cycle write never affects the word being read.
    always_ff @(posedge clk) begin
        if (bm_wr_en) mem[bm_wr_addr] <= bm_wr_data;
        if (state == S_READ) rd_data <= mem[pix];
    end

    // avail_q resets high so a level already high at reset release does not start a scan.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            avail_q  <= 1'b1;
            pix      <= '0;
            row      <= '0;
            col      <= '0;
            pending  <= '0;
            ev_valid <= 1'b0;
            ev_ch    <= '0;
            ev_row   <= '0;
            ev_col   <= '0;
            ts_done  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            avail_q <= input_avail;
            ts_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (input_avail && !avail_q) begin
                        state <= S_READ;
                        busy  <= 1'b1;
                        pix   <= '0;
                        row   <= '0;
                        col   <= '0;
                    end
                end
                S_READ: state <= S_LOAD;
                S_LOAD: begin
                    pending <= rd_data;
                    ev_row  <= row;
                    ev_col  <= col;
                    if (rd_data != '0) begin
                        state    <= S_EMIT;
                        ev_valid <= 1'b1;
                        ev_ch    <= lowest_ch(rd_data);
                    end
                end
                S_EMIT: begin
                    if (ev_ready) begin
                        pending <= remaining;
                        if (remaining != '0) ev_ch <= lowest_ch(remaining);
                        else ev_valid <= 1'b0;
                    end
                end
                S_DONE: begin
                    ts_done <= 1'b1;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (advance) begin
                if (last_pix) begin
                    state <= S_DONE;
                end else begin
                    state <= S_READ;
                    pix   <= pix + ADDR_W'(1);
                    col   <= col_wrap ? '0 : col + COORD_W'(1);
                    if (col_wrap) row <= row + COORD_W'(1);
                end
            end
        end
    end

`ifdef INPUT_SPIKE_EVENT_COUNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ev_count <= '0;
        end else if (state == S_IDLE && input_avail && !avail_q) begin
            ev_count <= '0;
        end else if (ev_valid && ev_ready) begin
            ev_count <= ev_count + (ADDR_W + CH_W + 1)'(1);
        end
    end
`endif

endmodule

// File: tb/tb_input_spike_encoder.sv
// Bench for input_spike_encoder: table-driven frames, hand-written corner sequences,
// and randomized frames scored against an event list derived from the bitmap.
module tb_input_spike_encoder;

    localparam int FW = 32;
    localparam int FRAME_SIZE = FW * FW;
    localparam int ADDR_W = 10;
    localparam int W = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              bm_wr_en = 1'b0;
    logic [ADDR_W-1:0] bm_wr_addr = '0;
    logic [2:0]        bm_wr_data = '0;
    logic              input_avail = 1'b0;
    logic              ev_ready = 1'b1;
    logic              ev_valid;
    logic [1:0]        ev_ch;
    logic [4:0]        ev_row;
    logic [4:0]        ev_col;
    logic              ts_done;
    logic              busy;
    logic [2:0]        state_dbg;
`ifdef INPUT_SPIKE_EVENT_COUNT_EN
    logic [12:0]       ev_count;
`endif

    input_spike_encoder dut (
        .clk(clk), .rst(rst), .bm_wr_en(bm_wr_en), .bm_wr_addr(bm_wr_addr),
        .bm_wr_data(bm_wr_data), .input_avail(input_avail), .ev_valid(ev_valid),
        .ev_ready(ev_ready), .ev_ch(ev_ch), .ev_row(ev_row), .ev_col(ev_col),
        .ts_done(ts_done), .busy(busy), .state_dbg(state_dbg)
`ifdef INPUT_SPIKE_EVENT_COUNT_EN
        , .ev_count(ev_count)
`endif
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int failed = 0;

    logic [2:0]   model_mem [FRAME_SIZE];
    logic [W-1:0] exp_q[$];
    int           got_events;
    int           got_stalls;
    logic [W-1:0] got_first;
    logic [W-1:0] got_last;
    logic         rdy_rand = 1'b0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_evt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] pk(input int ch, input int r, input int c);
        return {ch[1:0], r[4:0], c[4:0]};
    endfunction

    // Reference: every set bit of every pixel, rows then columns then channels.
    task automatic build_expect(output int n);
        exp_q.delete();
        n = 0;
        for (int r = 0; r < FW; r++)
            for (int c = 0; c < FW; c++)
                for (int ch = 0; ch < 3; ch++)
                    if (model_mem[r*FW + c][ch]) begin
                        exp_q.push_back(pk(ch, r, c));
                        n++;
                    end
    endtask

    task automatic write_frame();
        for (int a = 0; a < FRAME_SIZE; a++) begin
            @(posedge clk); #1;
            bm_wr_en = 1'b1;
            bm_wr_addr = a[ADDR_W-1:0];
            bm_wr_data = model_mem[a];
        end
        @(posedge clk); #1;
        bm_wr_en = 1'b0;
    endtask

    task automatic clear_model();
        for (int a = 0; a < FRAME_SIZE; a++) model_mem[a] = '0;
    endtask

    // Random backpressure driver.
    always @(posedge clk) begin
        #1;
        if (rdy_rand) ev_ready = ($urandom_range(0, 3) != 0);
    end

    // Scoreboard and handshake-stability monitor.
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", {31'd0, ev_valid}, 32'd1);
                if (ev_valid) check("hold_fields", {20'd0, ev_ch, ev_row, ev_col}, {20'd0, prev_evt});
            end
            if (ev_valid) begin
                if (ev_ready) begin
                    if (exp_q.size() == 0) begin
                        tests_run++;
                        failed++;
                        $display("FAIL unexpected_event: got 0x%0h expected none", {ev_ch, ev_row, ev_col});
                    end else begin
                        check("event", {20'd0, ev_ch, ev_row, ev_col}, {20'd0, exp_q.pop_front()});
                    end
                    if (got_events == 0) got_first = {ev_ch, ev_row, ev_col};
                    got_last = {ev_ch, ev_row, ev_col};
                    got_events++;
                end else begin
                    got_stalls++;
                end
                prev_stall = !ev_ready;
                prev_evt = {ev_ch, ev_row, ev_col};
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // Makes a fresh rising edge, then counts clock edges from the start edge to ts_done.
    task automatic run_scan(input bit drop_avail, output int cycles, output bit busy_ok, output bit one_shot);
        bit done;
        got_events = 0;
        got_stalls = 0;
        @(posedge clk); #1 input_avail = 1'b0;
        @(posedge clk); #1 input_avail = 1'b1;
        @(posedge clk);
        cycles = 0;
        busy_ok = 1'b1;
        one_shot = 1'b1;
        done = 1'b0;
        while (!done && cycles < 6000) begin
            @(posedge clk);
            cycles++;
            #1;
            if (drop_avail && cycles == 3) input_avail = 1'b0;
            @(negedge clk);
            if (ts_done) done = 1'b1;
            else if (!busy) busy_ok = 1'b0;
        end
        if (!done) begin
            tests_run++;
            failed++;
            $display("FAIL scan_timeout: got no ts_done expected ts_done within 6000 cycles");
        end else begin
            if (busy) one_shot = 1'b0;
            @(negedge clk);
            if (ts_done) one_shot = 1'b0;
        end
    endtask

    typedef struct {
        int           addr_a;
        logic [2:0]   data_a;
        int           addr_b;
        logic [2:0]   data_b;
        int           exp_events;
        logic [W-1:0] exp_first;
        logic [W-1:0] exp_last;
        int           exp_cycles;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int  n;
        int  cyc;
        bit  bok;
        bit  one;
        int  bad;
        bit  seen;

        vecs[0] = '{33,   3'b010, 33,  3'b010, 1, pk(1, 1, 1),  pk(1, 1, 1),   2050};
        vecs[1] = '{0,    3'b111, 0,   3'b111, 3, pk(0, 0, 0),  pk(2, 0, 0),   2052};
        vecs[2] = '{1023, 3'b100, 31,  3'b001, 2, pk(0, 0, 31), pk(2, 31, 31), 2051};
        vecs[3] = '{0,    3'b000, 0,   3'b000, 0, pk(0, 0, 0),  pk(0, 0, 0),   2049};
        vecs[4] = '{32,   3'b011, 992, 3'b001, 3, pk(0, 1, 0),  pk(0, 31, 0),  2052};

        #7;
        check("rst_ev_valid", {31'd0, ev_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ts_done", {31'd0, ts_done}, 32'd0);
        check("rst_fields", {20'd0, ev_ch, ev_row, ev_col}, 32'd0);
`ifdef INPUT_SPIKE_EVENT_COUNT_EN
        check("rst_ev_count", {19'd0, ev_count}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            clear_model();
            model_mem[vecs[i].addr_a] = vecs[i].data_a;
            model_mem[vecs[i].addr_b] = model_mem[vecs[i].addr_b] | vecs[i].data_b;
            write_frame();
            build_expect(n);
            rdy_rand = 1'b0;
            ev_ready = 1'b1;
            run_scan(1'b1, cyc, bok, one);
            check($sformatf("v%0d_events", i), got_events, vecs[i].exp_events);
            if (vecs[i].exp_events > 0) begin
                check($sformatf("v%0d_first", i), {20'd0, got_first}, {20'd0, vecs[i].exp_first});
                check($sformatf("v%0d_last", i), {20'd0, got_last}, {20'd0, vecs[i].exp_last});
            end
            check($sformatf("v%0d_cycles", i), cyc, vecs[i].exp_cycles);
            check($sformatf("v%0d_drained", i), exp_q.size(), 0);
            check($sformatf("v%0d_busy", i), {31'd0, bok}, 32'd1);
            check($sformatf("v%0d_ts_pulse", i), {31'd0, one}, 32'd1);
`ifdef INPUT_SPIKE_EVENT_COUNT_EN
            check($sformatf("v%0d_ev_count", i), {19'd0, ev_count}, vecs[i].exp_events);
`endif
        end

        // Last pixel / wrap frame: held-high level must not retrigger, a new edge repeats output.
        clear_model();
        model_mem[1023] = 3'b100;
        model_mem[31] = 3'b001;
        write_frame();
        build_expect(n);
        run_scan(1'b0, cyc, bok, one);
        check("hold_events", got_events, 2);
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (busy || ev_valid) bad++;
        end
        check("no_retrigger", bad, 0);
        build_expect(n);
        run_scan(1'b1, cyc, bok, one);
        check("rerun_first", {20'd0, got_first}, {20'd0, pk(0, 0, 31)});
        check("rerun_last", {20'd0, got_last}, {20'd0, pk(2, 31, 31)});
        check("rerun_cycles", cyc, 2051);
        check("rerun_drained", exp_q.size(), 0);

        // Multi-channel pixel under a 5-cycle stall.
        clear_model();
        model_mem[0] = 3'b111;
        write_frame();
        build_expect(n);
        ev_ready = 1'b0;
        got_events = 0;
        @(posedge clk); #1 input_avail = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (ev_valid) seen = 1'b1;
        end
        check("bp_valid", {31'd0, seen}, 32'd1);
        check("bp_fields", {20'd0, ev_ch, ev_row, ev_col}, {20'd0, pk(0, 0, 0)});
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        ev_ready = 1'b1;
        input_avail = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clk);
            if (ts_done) seen = 1'b1;
        end
        check("bp_ts_done", {31'd0, seen}, 32'd1);
        check("bp_events", got_events, 3);
        check("bp_drained", exp_q.size(), 0);
`ifdef INPUT_SPIKE_EVENT_COUNT_EN
        check("bp_ev_count", {19'd0, ev_count}, 32'd3);
`endif

        // Asynchronous reset while an event is stalled; input_avail stays high through release.
        ev_ready = 1'b0;
        build_expect(n);
        @(posedge clk); #1 input_avail = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (ev_valid) seen = 1'b1;
        end
        check("rstmid_valid_before", {31'd0, seen}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rstmid_ev_valid", {31'd0, ev_valid}, 32'd0);
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_ts_done", {31'd0, ts_done}, 32'd0);
        exp_q.delete();
        ev_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int k = 0; k < 2200; k++) begin
            @(negedge clk);
            if (ts_done || busy || ev_valid) bad++;
        end
        check("rstmid_no_scan", bad, 0);
        input_avail = 1'b0;

        // Randomized frames with random backpressure.
        for (int it = 0; it < 2; it++) begin
            for (int a = 0; a < FRAME_SIZE; a++)
                model_mem[a] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            write_frame();
            build_expect(n);
            rdy_rand = 1'b1;
            run_scan(1'b1, cyc, bok, one);
            rdy_rand = 1'b0;
            #2 ev_ready = 1'b1;
            check($sformatf("rnd%0d_events", it), got_events, n);
            check($sformatf("rnd%0d_drained", it), exp_q.size(), 0);
            check($sformatf("rnd%0d_cycles", it), cyc, 2*FRAME_SIZE + 1 + n + got_stalls);
`ifdef INPUT_SPIKE_EVENT_COUNT_EN
            check($sformatf("rnd%0d_ev_count", it), {19'd0, ev_count}, n);
`endif
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
